pipelined_adder: RTL

- Parametrised, pipelined successor to the 16-bit ripple-carry adder.
- The WIDTH-bit operands are split into STAGES equal segments, and each pipeline stage adds one segment.
- A registered carry passes between stages, and skew registers keep each operand's segments aligned as they move down the pipe.
- Adds a subtract mode, signed-overflow detection and a valid/ready handshake at input and output. It feeds the datapath ALU, replacing the combinational 16-bit adder on timing-critical paths.

---
 rtl/pipelined_adder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
`default_nettype none
// =============================================================================
// pipelined_adder : WIDTH-bit add/subtract split into STAGES carry-linked
//                   segments, with valid/ready flow control at both ends.
// Revision        : 1.0
// =============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] F,
  output logic             COUT,
  output logic             OVF
);

  localparam int SEG = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] b_cond;
  logic             cin_cond;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // A single advance enable stalls every stage together.
  assign en       = !out_valid_q || OUT_READY;
  assign IN_READY = en;

  assign b_cond   = SUB ? ~B : B;
  assign cin_cond = SUB ? 1'b1 : C;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]    a_in;
    logic [REM-1:0]    b_in;
    logic              carry_in;
    logic              valid_in;
    logic [LO+SEG-1:0] sum_acc;
    logic [SEG:0]      seg_sum;

    // Operands arrive with already-consumed low segments stripped off,
    // so the segment this stage adds is always at the bottom.
    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, carry_in};

    if (k == 0) begin : g_src_port
      assign a_in     = A;
      assign b_in     = b_cond;
      assign carry_in = cin_cond;
      assign valid_in = IN_VALID;
      assign sum_acc  = seg_sum[SEG-1:0];
    end else begin : g_src_prev
      assign a_in     = g_stage[k-1].g_mid.a_q;
      assign b_in     = g_stage[k-1].g_mid.b_q;
      assign carry_in = g_stage[k-1].g_mid.carry_q;
      assign valid_in = g_stage[k-1].g_mid.valid_q;
      assign sum_acc  = {seg_sum[SEG-1:0], g_stage[k-1].g_mid.sum_q};
    end

    if (k < STAGES - 1) begin : g_mid
      logic [REM-SEG-1:0] a_q, a_d;
      logic [REM-SEG-1:0] b_q, b_d;
      logic [LO+SEG-1:0]  sum_q, sum_d;
      logic               carry_q, carry_d;
      logic               valid_q, valid_d;

      always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = valid_q;
        if (en) begin
          valid_d = valid_in;
          if (valid_in) begin
            a_d     = a_in[REM-1:SEG];
            b_d     = b_in[REM-1:SEG];
            sum_d   = sum_acc;
            carry_d = seg_sum[SEG];
          end
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          a_q     <= '0;
          b_q     <= '0;
          sum_q   <= '0;
          carry_q <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          a_q     <= a_d;
          b_q     <= b_d;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          valid_q <= valid_d;
        end
      end
    end else begin : g_last
      // Only the top segment remains here, so bit REM-1 is the operand MSB.
      always_comb begin
        out_valid_d = out_valid_q;
        f_d         = f_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (en) begin
          out_valid_d = valid_in;
          if (valid_in) begin
            f_d    = sum_acc;
            cout_d = seg_sum[SEG];
            ovf_d  = (a_in[REM-1] == b_in[REM-1]) && (seg_sum[SEG-1] != a_in[REM-1]);
          end
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          out_valid_q <= 1'b0;
          f_q         <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
        end else begin
          out_valid_q <= out_valid_d;
          f_q         <= f_d;
          cout_q      <= cout_d;
          ovf_q       <= ovf_d;
        end
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign F         = f_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;

endmodule
`default_nettype wire
